mcb_port_resp: RTL and testbench

Synthesizable responder for one Spartan-6 MCB user port (command, write-data and read-data channels), backed by on-chip block RAM. It sits on the far side of `eth_mcb_if` in place of the real MCB/DDR, so the Ethernet datapath can run in simulation and in hardware bring-up without external memory. It reproduces MCB port semantics: FIFO flags, counts, error and underrun/overflow indications, burst commands, and byte masks.

---
 rtl/mcb_port_resp.sv | 221 ++++++++++++++++++++++
 tb/tb_mcb_port_resp.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_port_resp.sv
// Block-RAM backed stand-in for one Spartan-6 MCB user port.
// Command, write-data and read-data FIFOs feed an in-order engine.
module mcb_port_resp #(
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mcb_cmd_en_in,
    input  logic [2:0]  mcb_cmd_instr_in,
    input  logic [5:0]  mcb_cmd_bl_in,
    input  logic [29:0] mcb_cmd_byte_addr_in,
    output logic        mcb_cmd_empty_out,
    output logic        mcb_cmd_full_out,
    input  logic        mcb_wr_en_in,
    input  logic [7:0]  mcb_wr_mask_in,
    input  logic [63:0] mcb_wr_data_in,
    output logic        mcb_wr_full_out,
    output logic        mcb_wr_empty_out,
    output logic [6:0]  mcb_wr_count_out,
    output logic        mcb_wr_error_out,
    output logic        mcb_wr_underrun_out,
    input  logic        mcb_rd_en_in,
    output logic [63:0] mcb_rd_data_out,
    output logic        mcb_rd_full_out,
    output logic        mcb_rd_empty_out,
    output logic [6:0]  mcb_rd_count_out,
    output logic        mcb_rd_error_out,
    output logic        mcb_rd_overflow_out
);

    localparam int PD = RD_LAT - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t state, state_nx;

    logic cmd_pop, wr_pop, issue;

    // command fifo: {instr, bl, byte_addr}
    logic [38:0] cmd_mem [4];
    logic [1:0]  cmd_wp, cmd_rp;
    logic [2:0]  cmd_cnt;
    logic        cmd_push_ok, cmd_pop_ok;
    logic [38:0] cmd_head;

    assign mcb_cmd_empty_out = (cmd_cnt == 3'd0);
    assign mcb_cmd_full_out  = (cmd_cnt == 3'd4);
    assign cmd_pop_ok  = cmd_pop && !mcb_cmd_empty_out;
    assign cmd_push_ok = mcb_cmd_en_in && (!mcb_cmd_full_out || cmd_pop_ok);
    assign cmd_head    = cmd_mem[cmd_rp];

    always_ff @(posedge clk) begin
        if (cmd_push_ok)
            cmd_mem[cmd_wp] <= {mcb_cmd_instr_in, mcb_cmd_bl_in, mcb_cmd_byte_addr_in};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmd_wp  <= '0;
            cmd_rp  <= '0;
            cmd_cnt <= '0;
        end else begin
            if (cmd_push_ok) cmd_wp <= cmd_wp + 2'd1;
            if (cmd_pop_ok)  cmd_rp <= cmd_rp + 2'd1;
            cmd_cnt <= cmd_cnt + {2'b0, cmd_push_ok} - {2'b0, cmd_pop_ok};
        end
    end

    // write fifo: {mask, data}
    logic [71:0] wr_mem [64];
    logic [5:0]  wr_wp, wr_rp;
    logic [6:0]  wr_cnt;
    logic        wr_push_ok, wr_pop_ok;
    logic [71:0] wr_head;

    assign mcb_wr_count_out = wr_cnt;
    assign mcb_wr_empty_out = (wr_cnt == 7'd0);
    assign mcb_wr_full_out  = (wr_cnt == 7'd64);
    assign wr_pop_ok  = wr_pop && !mcb_wr_empty_out;
    assign wr_push_ok = mcb_wr_en_in && (!mcb_wr_full_out || wr_pop_ok);
    assign wr_head    = wr_mem[wr_rp];
    assign mcb_wr_underrun_out = (state == S_WRITE) && mcb_wr_empty_out;

    always_ff @(posedge clk) begin
        if (wr_push_ok)
            wr_mem[wr_wp] <= {mcb_wr_mask_in, mcb_wr_data_in};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_wp <= '0;
            wr_rp <= '0;
            wr_cnt <= '0;
            mcb_wr_error_out <= 1'b0;
        end else begin
            if (wr_push_ok) wr_wp <= wr_wp + 6'd1;
            if (wr_pop_ok)  wr_rp <= wr_rp + 6'd1;
            wr_cnt <= wr_cnt + {6'b0, wr_push_ok} - {6'b0, wr_pop_ok};
            if (mcb_wr_en_in && !wr_push_ok) mcb_wr_error_out <= 1'b1;
        end
    end

    // engine beat counter and word address
    logic [6:0]        beats;
    logic [MEM_AW-1:0] addr;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{cmd_head[2:0], cmd_head[29:MEM_AW+3]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            beats <= '0;
            addr  <= '0;
        end else if (cmd_pop_ok) begin
            beats <= {1'b0, cmd_head[35:30]} + 7'd1;
            addr  <= cmd_head[MEM_AW+2:3];
        end else if (wr_pop_ok || issue) begin
            beats <= beats - 7'd1;
            addr  <= addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    logic [PD-1:0] pipe_v;

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (!mcb_cmd_empty_out) begin
                    unique case (cmd_head[38:36])
                        3'b000, 3'b010: state_nx = S_WRITE;
                        3'b001, 3'b011: state_nx = S_READ;
                        default:        state_nx = S_IDLE;
                    endcase
                end
            end
            S_WRITE: if (wr_pop_ok && beats == 7'd1) state_nx = S_IDLE;
            S_READ:  if (beats == 7'd1) state_nx = S_DRAIN;
            S_DRAIN: if (pipe_v == '0) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_pop = (state == S_IDLE) && !mcb_cmd_empty_out;
        wr_pop  = (state == S_WRITE) && !mcb_wr_empty_out;
        issue   = (state == S_READ);
    end

    // backing RAM; pipe_d[0] is the registered RAM output
    logic [63:0] ram [2**MEM_AW];
    logic [63:0] pipe_d [PD];

    always_ff @(posedge clk) begin
        if (wr_pop_ok) begin
            for (int b = 0; b < 8; b++)
                if (!wr_head[64+b])
                    ram[addr][b*8 +: 8] <= wr_head[b*8 +: 8];
        end
        pipe_d[0] <= ram[addr];
        for (int k = 1; k < PD; k++)
            pipe_d[k] <= pipe_d[k-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= issue;
            for (int k = 1; k < PD; k++)
                pipe_v[k] <= pipe_v[k-1];
        end
    end

    // read fifo, first-word fall-through
    logic [63:0] rd_mem [64];
    logic [5:0]  rd_wp, rd_rp;
    logic [6:0]  rd_cnt;
    logic        rd_push, rd_push_ok, rd_pop_ok;

    assign rd_push = pipe_v[PD-1];
    assign mcb_rd_count_out = rd_cnt;
    assign mcb_rd_empty_out = (rd_cnt == 7'd0);
    assign mcb_rd_full_out  = (rd_cnt == 7'd64);
    assign rd_pop_ok  = mcb_rd_en_in && !mcb_rd_empty_out;
    assign rd_push_ok = rd_push && (!mcb_rd_full_out || rd_pop_ok);
    assign mcb_rd_data_out = mcb_rd_empty_out ? 64'd0 : rd_mem[rd_rp];

    always_ff @(posedge clk) begin
        if (rd_push_ok)
            rd_mem[rd_wp] <= pipe_d[PD-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_wp <= '0;
            rd_rp <= '0;
            rd_cnt <= '0;
            mcb_rd_error_out <= 1'b0;
            mcb_rd_overflow_out <= 1'b0;
        end else begin
            if (rd_push_ok) rd_wp <= rd_wp + 6'd1;
            if (rd_pop_ok)  rd_rp <= rd_rp + 6'd1;
            rd_cnt <= rd_cnt + {6'b0, rd_push_ok} - {6'b0, rd_pop_ok};
            if (mcb_rd_en_in && mcb_rd_empty_out) mcb_rd_error_out <= 1'b1;
            if (rd_push && !rd_push_ok) mcb_rd_overflow_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mcb_port_resp.sv
// Scoreboard bench for mcb_port_resp: stimulus queues expected read words,
// a negedge monitor compares every popped word.
module tb_mcb_port_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_en = 1'b0;
    logic [2:0]  cmd_instr = '0;
    logic [5:0]  cmd_bl = '0;
    logic [29:0] cmd_addr = '0;
    logic        cmd_empty, cmd_full;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_mask = '0;
    logic [63:0] wr_data = '0;
    logic        wr_full, wr_empty, wr_error, wr_underrun;
    logic [6:0]  wr_count;
    logic        rd_en = 1'b0;
    logic [63:0] rd_data;
    logic        rd_full, rd_empty, rd_error, rd_overflow;
    logic [6:0]  rd_count;

    int n_checks = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_w;

    localparam logic [63:0] BASE = 64'h0123_4567_89AB_CD00;
    localparam logic [63:0] FILL = 64'hC0DE_0000_0000_0000;

    mcb_port_resp #(.MEM_AW(10), .RD_LAT(4)) dut (
        .clk(clk),
        .rst(rst),
        .mcb_cmd_en_in(cmd_en),
        .mcb_cmd_instr_in(cmd_instr),
        .mcb_cmd_bl_in(cmd_bl),
        .mcb_cmd_byte_addr_in(cmd_addr),
        .mcb_cmd_empty_out(cmd_empty),
        .mcb_cmd_full_out(cmd_full),
        .mcb_wr_en_in(wr_en),
        .mcb_wr_mask_in(wr_mask),
        .mcb_wr_data_in(wr_data),
        .mcb_wr_full_out(wr_full),
        .mcb_wr_empty_out(wr_empty),
        .mcb_wr_count_out(wr_count),
        .mcb_wr_error_out(wr_error),
        .mcb_wr_underrun_out(wr_underrun),
        .mcb_rd_en_in(rd_en),
        .mcb_rd_data_out(rd_data),
        .mcb_rd_full_out(rd_full),
        .mcb_rd_empty_out(rd_empty),
        .mcb_rd_count_out(rd_count),
        .mcb_rd_error_out(rd_error),
        .mcb_rd_overflow_out(rd_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    // monitor: a word is consumed at the next posedge when rd_en is high
    always @(negedge clk) begin
        if (rst && rd_en && !rd_empty) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_word: got %h, required no word", rd_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (rd_data !== exp_w) begin
                    n_fail++;
                    $display("FAIL rd_word: got %h, required %h", rd_data, exp_w);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] ins, input logic [5:0] bl, input logic [29:0] a);
        cmd_en = 1'b1;
        cmd_instr = ins;
        cmd_bl = bl;
        cmd_addr = a;
        step(1);
        cmd_en = 1'b0;
    endtask

    task automatic wr_word(input logic [63:0] d, input logic [7:0] m);
        wr_en = 1'b1;
        wr_data = d;
        wr_mask = m;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_wr_empty(input int budget);
        int b = 0;
        while (!wr_empty && b < budget) begin
            step(1);
            b++;
        end
        check("wait_wr_empty", {63'd0, wr_empty}, 64'd1);
    endtask

    task automatic wait_rd(input int n, input int budget);
        int b = 0;
        while (int'(rd_count) < n && b < budget) begin
            step(1);
            b++;
        end
        n_checks++;
        if (int'(rd_count) < n) begin
            n_fail++;
            $display("FAIL wait_rd: got count %0d, required %0d", rd_count, n);
        end
    endtask

    task automatic pop_n(input int n);
        rd_en = 1'b1;
        step(n);
        rd_en = 1'b0;
    endtask

    task automatic check_reset();
        check("rst_cmd_empty", {63'd0, cmd_empty}, 64'd1);
        check("rst_cmd_full", {63'd0, cmd_full}, 64'd0);
        check("rst_wr_empty", {63'd0, wr_empty}, 64'd1);
        check("rst_wr_full", {63'd0, wr_full}, 64'd0);
        check("rst_wr_count", {57'd0, wr_count}, 64'd0);
        check("rst_wr_error", {63'd0, wr_error}, 64'd0);
        check("rst_wr_underrun", {63'd0, wr_underrun}, 64'd0);
        check("rst_rd_empty", {63'd0, rd_empty}, 64'd1);
        check("rst_rd_full", {63'd0, rd_full}, 64'd0);
        check("rst_rd_count", {57'd0, rd_count}, 64'd0);
        check("rst_rd_error", {63'd0, rd_error}, 64'd0);
        check("rst_rd_overflow", {63'd0, rd_overflow}, 64'd0);
        check("rst_rd_data", rd_data, 64'd0);
    endtask

    initial begin
        step(2);
        check_reset();
        rst = 1'b1;
        step(1);

        // 8-word write then read with latency check
        for (int i = 0; i < 8; i++) wr_word(BASE + 64'(i), 8'h00);
        cmd(3'b000, 6'd7, 30'h40);
        wait_wr_empty(50);
        cmd(3'b001, 6'd7, 30'h40);
        for (int i = 0; i < 8; i++) exp_q.push_back(BASE + 64'(i));
        step(4);
        check("lat_before", {63'd0, rd_empty}, 64'd1);
        step(1);
        check("lat_at", {63'd0, rd_empty}, 64'd0);
        check("lat_data", rd_data, BASE);
        wait_rd(8, 50);
        pop_n(8);

        // masked write
        wr_word(64'h1111_1111_1111_1111, 8'h00);
        wr_word(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        cmd(3'b000, 6'd0, 30'h200);
        cmd(3'b010, 6'd0, 30'h200);
        cmd(3'b011, 6'd0, 30'h200);
        exp_q.push_back(64'hFFFF_FFFF_1111_1111);
        wait_rd(1, 50);
        pop_n(1);

        // wrap at top of RAM: words 1022,1023,0,1
        for (int i = 0; i < 4; i++) wr_word(64'hA0A0_0000_0000_0000 + 64'(i), 8'h00);
        cmd(3'b000, 6'd3, 30'h1FF0);
        cmd(3'b001, 6'd3, 30'h1FF0);
        cmd(3'b001, 6'd1, 30'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back(64'hA0A0_0000_0000_0000 + 64'(i));
        exp_q.push_back(64'hA0A0_0000_0000_0002);
        exp_q.push_back(64'hA0A0_0000_0000_0003);
        wait_rd(6, 80);
        pop_n(6);

        // underrun with trickled data
        cmd(3'b000, 6'd3, 30'h300);
        step(2);
        check("underrun_wait", {63'd0, wr_underrun}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            wr_word(64'hBEEF_0000_0000_0000 + 64'(i), 8'h00);
            check("underrun_data", {63'd0, wr_underrun}, 64'd0);
            step(1);
            check("underrun_pop", {63'd0, wr_underrun}, (i < 3) ? 64'd1 : 64'd0);
            step(1);
        end
        cmd(3'b001, 6'd3, 30'h300);
        for (int i = 0; i < 4; i++) exp_q.push_back(64'hBEEF_0000_0000_0000 + 64'(i));
        wait_rd(4, 50);
        pop_n(4);

        // fill write fifo, 65th push rejected
        for (int i = 0; i < 65; i++) begin
            wr_word(FILL + 64'(i), 8'h00);
            if (i == 63) begin
                check("wr_full64", {63'd0, wr_full}, 64'd1);
                check("wr_count64", {57'd0, wr_count}, 64'd64);
                check("wr_error_pre", {63'd0, wr_error}, 64'd0);
            end
        end
        check("wr_error", {63'd0, wr_error}, 64'd1);
        check("wr_count65", {57'd0, wr_count}, 64'd64);
        cmd(3'b000, 6'd63, 30'h1000);
        wait_wr_empty(100);

        // pop empty read fifo
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("rd_error", {63'd0, rd_error}, 64'd1);
        check("rd_count_err", {57'd0, rd_count}, 64'd0);

        // overflow: two 64-word reads, no pops
        cmd(3'b001, 6'd63, 30'h1000);
        cmd(3'b001, 6'd63, 30'h1000);
        step(200);
        check("ovf_count", {57'd0, rd_count}, 64'd64);
        check("ovf_full", {63'd0, rd_full}, 64'd1);
        check("ovf_flag", {63'd0, rd_overflow}, 64'd1);
        for (int i = 0; i < 64; i++) exp_q.push_back(FILL + 64'(i));
        pop_n(64);
        check("ovf_drained", {63'd0, rd_empty}, 64'd1);

        // reset during an active read burst
        cmd(3'b001, 6'd63, 30'h1000);
        step(10);
        check("burst_active", {63'd0, rd_empty}, 64'd0);
        rst = 1'b0;
        step(2);
        check_reset();
        rst = 1'b1;
        step(10);
        check("post_rst_empty", {63'd0, rd_empty}, 64'd1);
        cmd(3'b001, 6'd1, 30'h40);
        exp_q.push_back(BASE);
        exp_q.push_back(BASE + 64'd1);
        wait_rd(2, 50);
        pop_n(2);

        step(2);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
